alu16_word_seq: RTL

- Sequencer that runs 16-bit word operations through the shared 8-bit 65CE02 ALU in two byte passes. Covers the word ops: add/sub, INW/DEW, ASW/ROW, ASRW/RORW.
- Accepts a request over a valid/ready handshake and drives the ALU control/operand inputs. It chains carry between the passes, assembles the 16-bit result and N/Z/C/V flags, and returns them over a valid/ready handshake.
- Sits beside the core's control logic. alu_sel steers the ALU input mux to this block while it owns the ALU.

---
 rtl/alu16_word_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu16_word_seq.sv
// Runs 16-bit word ops through the shared 8-bit ALU as two byte passes.
// Chains carry between passes and returns the word result with N/Z/C/V flags.
module alu16_word_seq #(
  parameter bit RDY_GATE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RDY,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_ci,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_n,
  output logic        res_z,
  output logic        res_c,
  output logic        res_v,
  output logic        alu_sel,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic        alu_arith,
  output logic [7:0]  alu_AI,
  output logic [7:0]  alu_BI,
  output logic        alu_CI,
  output logic        alu_BCD,
  input  logic [7:0]  alu_OUT,
  input  logic        alu_CO,
  input  logic        alu_V
);

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_INW  = 3'b010;
  localparam logic [2:0] CMD_DEW  = 3'b011;
  localparam logic [2:0] CMD_ASW  = 3'b100;
  localparam logic [2:0] CMD_ROW  = 3'b101;
  localparam logic [2:0] CMD_ASRW = 3'b110;
  localparam logic [2:0] CMD_RORW = 3'b111;

  typedef enum logic [2:0] {IDLE, P1, P2, FIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        ci_q, ci_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_n_q, res_n_d;
  logic        res_z_q, res_z_d;
  logic        res_c_q, res_c_d;
  logic        res_v_q, res_v_d;

  logic        adv;
  logic        is_right;
  logic        first;
  logic        lo_sel;
  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [15:0] word;
  logic        first_ci;

  assign adv      = RDY | ~RDY_GATE;
  assign is_right = cmd_q[2] & cmd_q[1];
  assign first    = (state_q == P1);
  // Right shifts walk high byte first so the carry moves downward.
  assign lo_sel   = first ^ is_right;
  assign a_byte   = lo_sel ? a_q[7:0] : a_q[15:8];
  assign b_byte   = lo_sel ? b_q[7:0] : b_q[15:8];
  assign word     = is_right ? {byte_q, alu_OUT} : {alu_OUT, byte_q};

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_n     = res_n_q;
  assign res_z     = res_z_q;
  assign res_c     = res_c_q;
  assign res_v     = res_v_q;
  assign alu_BCD   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= 3'b000;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      ci_q       <= 1'b0;
      byte_q     <= 8'h00;
      res_data_q <= 16'h0000;
      res_n_q    <= 1'b0;
      res_z_q    <= 1'b0;
      res_c_q    <= 1'b0;
      res_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      byte_q     <= byte_d;
      res_data_q <= res_data_d;
      res_n_q    <= res_n_d;
      res_z_q    <= res_z_d;
      res_c_q    <= res_c_d;
      res_v_q    <= res_v_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    ci_d       = ci_q;
    byte_d     = byte_q;
    res_data_d = res_data_q;
    res_n_d    = res_n_q;
    res_z_d    = res_z_q;
    res_c_d    = res_c_q;
    res_v_d    = res_v_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d   = req_cmd;
          a_d     = req_a;
          b_d     = req_b;
          ci_d    = req_ci;
          state_d = P1;
        end
      end
      P1: if (adv) state_d = P2;
      P2: begin
        if (adv) begin
          byte_d  = alu_OUT;
          state_d = FIN;
        end
      end
      FIN: begin
        res_data_d = word;
        res_c_d    = alu_CO;
        res_n_d    = word[15];
        res_z_d    = (word == 16'h0000);
        res_v_d    = ~cmd_q[2] & alu_V;
        state_d    = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte 2 always takes the ALU's registered carry from byte 1.
  always_comb begin
    alu_sel   = 1'b0;
    alu_op    = 4'b0000;
    alu_right = 1'b0;
    alu_arith = 1'b0;
    alu_AI    = 8'h00;
    alu_BI    = 8'h00;
    alu_CI    = 1'b0;
    first_ci  = 1'b0;
    if (state_q == P1 || state_q == P2) begin
      alu_sel = 1'b1;
      alu_AI  = a_byte;
      case (cmd_q)
        CMD_ADD: begin
          alu_op   = 4'b0011;
          alu_BI   = b_byte;
          first_ci = ci_q;
        end
        CMD_SUB: begin
          alu_op   = 4'b0111;
          alu_BI   = b_byte;
          first_ci = ci_q;
        end
        CMD_INW: begin
          alu_op   = 4'b0011;
          first_ci = 1'b1;
        end
        CMD_DEW: begin
          alu_op   = 4'b0111;
          alu_BI   = first ? 8'h01 : 8'h00;
          first_ci = 1'b1;
        end
        CMD_ASW: alu_op = 4'b1011;
        CMD_ROW: begin
          alu_op   = 4'b1011;
          first_ci = ci_q;
        end
        CMD_ASRW: begin
          alu_op    = 4'b1111;
          alu_right = 1'b1;
          alu_arith = first;
        end
        CMD_RORW: begin
          alu_op    = 4'b1111;
          alu_right = 1'b1;
          first_ci  = ci_q;
        end
        default: alu_op = 4'b0000;
      endcase
      alu_CI = first ? first_ci : alu_CO;
    end
  end

endmodule
